// File: rtl/pixel_src_switch.sv
// pixel_src_switch
// Registered N-source pixel selector for the VGA display path. The active
// source changes only on a start-of-frame pulse, so no frame mixes sources.
// Two-cycle pipeline: stage 1 captures the selected source pixel(s) and the
// valid, and stage 2 produces the (optionally blended) pixel, zeroed when the
// pixel is not valid.
// Optional feature: define PIXEL_SRC_SWITCH_FADE_EN to crossfade from the old
// source to the new one over 2**FADE_LOG2 frames instead of switching hard.
module pixel_src_switch #(
  parameter int NUM_SRC   = 4,
  parameter int CH_W      = 4,
  parameter int SEL_W     = $clog2(NUM_SRC),
  parameter int FADE_LOG2 = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*3*CH_W-1:0] src_pix,
  input  logic                      pix_valid,
  input  logic                      sof,
  output logic [3*CH_W-1:0]         o_pix,
  output logic                      o_valid,
  output logic [SEL_W-1:0]          active_sel,
  output logic                      busy
);

  localparam int PIX_W = 3 * CH_W;

  if (NUM_SRC < 2 || NUM_SRC > 16 || FADE_LOG2 < 1 || SEL_W != $clog2(NUM_SRC)) begin : g_bad_param
    $error("pixel_src_switch: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FADE    = 2'd2
  } state_t;

  state_t state;

  logic             sel_ok;
  logic             req;
  logic [PIX_W-1:0] old_p1;
  logic             vld_p1;

`ifdef PIXEL_SRC_SWITCH_FADE_EN
  localparam int F     = 1 << FADE_LOG2;
  localparam int K_W   = FADE_LOG2 + 1;
  localparam int ACC_W = CH_W + FADE_LOG2 + 1;

  logic [SEL_W-1:0] target;
  logic [K_W-1:0]   k;
  logic [PIX_W-1:0] new_p1;
  logic [K_W-1:0]   k_p1;

  // Weighted mix of one channel; the result is truncated, not rounded.
  function automatic logic [CH_W-1:0] blend_ch(input logic [CH_W-1:0] a,
                                               input logic [CH_W-1:0] b,
                                               input logic [K_W-1:0]  kk);
    logic [ACC_W-1:0] acc;
    acc = ACC_W'(a) * (ACC_W'(F) - ACC_W'(kk)) + ACC_W'(b) * ACC_W'(kk);
    return CH_W'(acc >> FADE_LOG2);
  endfunction

  function automatic logic [PIX_W-1:0] blend_pix(input logic [PIX_W-1:0] a,
                                                 input logic [PIX_W-1:0] b,
                                                 input logic [K_W-1:0]   kk);
    logic [PIX_W-1:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      r[c*CH_W +: CH_W] = blend_ch(a[c*CH_W +: CH_W], b[c*CH_W +: CH_W], kk);
    end
    return r;
  endfunction
`endif

  // Pick one pixel out of the flattened source bus.
  function automatic logic [PIX_W-1:0] pick_src(input logic [NUM_SRC*PIX_W-1:0] all,
                                                input logic [SEL_W-1:0]         idx);
    logic [PIX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (idx == SEL_W'(i)) r = all[i*PIX_W +: PIX_W];
    end
    return r;
  endfunction

  // A select code beyond the last source counts as "no request".
  assign sel_ok = ({1'b0, sel} < (SEL_W+1)'(NUM_SRC));
  assign req    = sel_ok && (sel != active_sel);

  // Control FSM: track the requested source and commit it only on sof.
  // IDLE and PENDING react to sel identically; PENDING only marks that a
  // request is waiting for the next frame start (busy).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      active_sel <= '0;
      busy       <= 1'b0;
`ifdef PIXEL_SRC_SWITCH_FADE_EN
      target     <= '0;
      k          <= '0;
`endif
    end else begin
      unique case (state)
        IDLE, PENDING: begin
          if (!req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sof) begin
`ifdef PIXEL_SRC_SWITCH_FADE_EN
            target <= sel;
            k      <= K_W'(1);
            state  <= FADE;
            busy   <= 1'b1;
`else
            active_sel <= sel;
            state      <= IDLE;
            busy       <= 1'b0;
`endif
          end else begin
`ifdef PIXEL_SRC_SWITCH_FADE_EN
            target <= sel;
`endif
            state <= PENDING;
            busy  <= 1'b1;
          end
        end
`ifdef PIXEL_SRC_SWITCH_FADE_EN
        FADE: begin
          // target is frozen and new requests are ignored until the fade ends
          if (sof) begin
            if (k == K_W'(F - 1)) begin
              active_sel <= target;
              k          <= '0;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              k <= k + K_W'(1);
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage 1: capture selected source pixel(s) ----
  always_ff @(posedge clk) begin
    old_p1 <= pick_src(src_pix, active_sel);
`ifdef PIXEL_SRC_SWITCH_FADE_EN
    new_p1 <= pick_src(src_pix, target);
    k_p1   <= k;
`endif
  end

  // Stage 1 valid travels alongside the captured pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= pix_valid;
    end
  end

  // ---- stage 2: blend (fade build) and force zero on invalid pixels ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_pix   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= vld_p1;
      if (vld_p1) begin
`ifdef PIXEL_SRC_SWITCH_FADE_EN
        o_pix <= blend_pix(old_p1, new_p1, k_p1);
`else
        o_pix <= old_p1;
`endif
      end else begin
        o_pix <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_src_switch.sv
// Testbench for pixel_src_switch: directed scenarios plus randomized traffic,
// all checked against a frame-level reference model of source switching.
module tb_pixel_src_switch;

  localparam int NUM_SRC   = 3;
  localparam int CH_W      = 4;
  localparam int SEL_W     = 2;
  localparam int PIX_W     = 3 * CH_W;
  localparam int SRC_W     = NUM_SRC * PIX_W;
  localparam int FADE_LOG2 = 2;
  localparam int F         = 1 << FADE_LOG2;

  logic             clk       = 1'b0;
  logic             reset     = 1'b0;
  logic [SEL_W-1:0] sel       = '0;
  logic [SRC_W-1:0] src_pix   = '0;
  logic             pix_valid = 1'b0;
  logic             sof       = 1'b0;
  logic [PIX_W-1:0] o_pix;
  logic             o_valid;
  logic [SEL_W-1:0] active_sel;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int               m_active = 0;
  int               m_target = 0;
  int               m_k      = 0;
  bit               m_busy   = 1'b0;
  logic [PIX_W-1:0] exp_now  = '0;
  logic [PIX_W-1:0] exp_d1   = '0;
  bit               vld_d1   = 1'b0;

  pixel_src_switch #(
    .NUM_SRC  (NUM_SRC),
    .CH_W     (CH_W),
    .FADE_LOG2(FADE_LOG2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .src_pix   (src_pix),
    .pix_valid (pix_valid),
    .sof       (sof),
    .o_pix     (o_pix),
    .o_valid   (o_valid),
    .active_sel(active_sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected displayed pixel: a weighted average of two sources per channel.
  function automatic logic [PIX_W-1:0] ref_pix(input int a, input int t, input int k);
    logic [PIX_W-1:0] o, n, r;
    int ov, nv;
    o = src_pix[a*PIX_W +: PIX_W];
    n = src_pix[t*PIX_W +: PIX_W];
    r = '0;
    for (int c = 0; c < 3; c++) begin
      ov = int'(o[c*CH_W +: CH_W]);
      nv = int'(n[c*CH_W +: CH_W]);
      r[c*CH_W +: CH_W] = CH_W'((ov * (F - k) + nv * k) / F);
    end
    return r;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit want, pend;
    exp_now = pix_valid ? ref_pix(m_active, m_target, m_k) : '0;
    want    = (int'(sel) < NUM_SRC) && (int'(sel) != m_active);
    pend    = 1'b0;
    if (m_k != 0) begin
      if (sof) begin
        if (m_k == F - 1) begin
          m_active = m_target;
          m_k      = 0;
        end else begin
          m_k++;
        end
      end
    end else if (want) begin
      if (sof) begin
`ifdef PIXEL_SRC_SWITCH_FADE_EN
        m_target = int'(sel);
        m_k      = 1;
`else
        m_active = int'(sel);
`endif
      end else begin
        m_target = int'(sel);
        pend     = 1'b1;
      end
    end
    m_busy = (m_k != 0) || pend;
  endtask

  // One clock: apply inputs, step model, then compare outputs after the edge.
  task automatic cyc(input bit s, input bit pv, input logic [SEL_W-1:0] sl);
    sof       = s;
    pix_valid = pv;
    sel       = sl;
    model_step();
    @(posedge clk);
    #1;
    check("pix", o_pix, exp_d1);
    check("valid", o_valid, vld_d1);
    check("active", active_sel, m_active);
    check("busy", busy, m_busy);
    exp_d1 = exp_now;
    vld_d1 = pv;
  endtask

  task automatic frame(input int len, input logic [SEL_W-1:0] sl);
    cyc(1'b1, 1'b1, sl);
    for (int i = 1; i < len; i++) cyc(1'b0, 1'b1, sl);
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_pix", o_pix, 0);
    check("rst_valid", o_valid, 0);
    check("rst_active", active_sel, 0);
    check("rst_busy", busy, 0);
    m_active = 0;
    m_target = 0;
    m_k      = 0;
    m_busy   = 1'b0;
    exp_d1   = '0;
    vld_d1   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [SEL_W-1:0] rsel;

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // 1: reset mid-frame, then src0 reaches the output two cycles later
    src_pix = {12'h0F0, 12'h00F, 12'hF00};
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 2'd0);
    do_reset();
    cyc(1'b0, 1'b1, 2'd0);
    cyc(1'b0, 1'b1, 2'd0);
    check("t1_pix", o_pix, 12'hF00);

    // 2: frame-aligned switch 0 -> 2
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'd2);
    check("t2_busy", busy, 1);
    check("t2_hold", o_pix, 12'hF00);
    cyc(1'b1, 1'b1, 2'd2);
`ifndef PIXEL_SRC_SWITCH_FADE_EN
    check("t2_act_sof", active_sel, 2);
    cyc(1'b0, 1'b1, 2'd2);
    cyc(1'b0, 1'b1, 2'd2);
    check("t2_pix", o_pix, 12'h0F0);
    check("t2_idle", busy, 0);
`endif
    for (int f = 1; f < F; f++) frame(4, 2'd2);
    cyc(1'b0, 1'b1, 2'd2);
    cyc(1'b0, 1'b1, 2'd2);
    check("t2_final_act", active_sel, 2);
    check("t2_final_pix", o_pix, 12'h0F0);

    // 3a: retarget 0 -> 1 -> 2 before sof
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'd2);
    for (int f = 0; f < F; f++) frame(5, 2'd2);
    check("t3_retarget", active_sel, 2);
    // 3b: cancel 0 -> 1 -> 0 before sof
    do_reset();
    cyc(1'b0, 1'b1, 2'd1);
    cyc(1'b0, 1'b1, 2'd1);
    check("t3_pend", busy, 1);
    cyc(1'b0, 1'b1, 2'd0);
    check("t3_cancel", busy, 0);
    cyc(1'b1, 1'b1, 2'd0);
    check("t3_noswitch", active_sel, 0);

    // 4a: out-of-range select is no request
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'd3);
    check("t4_inv_busy", busy, 0);
    cyc(1'b1, 1'b1, 2'd3);
    check("t4_inv_act", active_sel, 0);
    // 4b: select change coincident with sof
    cyc(1'b1, 1'b1, 2'd1);
`ifndef PIXEL_SRC_SWITCH_FADE_EN
    check("t4_coinc", active_sel, 1);
`endif
    for (int f = 1; f < F; f++) frame(5, 2'd1);
    check("t4_coinc_final", active_sel, 1);

    // 5: ten invalid pixels produce ten zero outputs, delayed by two
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 2'd1);
      if (i >= 1) begin
        check("t5_valid", o_valid, 0);
        check("t5_pix", o_pix, 0);
      end
    end
    cyc(1'b0, 1'b1, 2'd1);
    check("t5_last_valid", o_valid, 0);
    cyc(1'b0, 1'b1, 2'd1);
    check("t5_resume", o_valid, 1);

`ifdef PIXEL_SRC_SWITCH_FADE_EN
    // 6: crossfade R from F to 0 over F-1 frames; mid-fade request ignored
    src_pix = {12'h0F0, 12'h000, 12'hF00};
    do_reset();
    cyc(1'b1, 1'b1, 2'd1);
    cyc(1'b0, 1'b1, 2'd1);
    cyc(1'b0, 1'b1, 2'd1);
    check("t6_k1", o_pix, 12'hB00);
    cyc(1'b1, 1'b1, 2'd2);
    cyc(1'b0, 1'b1, 2'd2);
    cyc(1'b0, 1'b1, 2'd2);
    check("t6_k2", o_pix, 12'h700);
    check("t6_busy", busy, 1);
    check("t6_hold_act", active_sel, 0);
    cyc(1'b1, 1'b1, 2'd2);
    cyc(1'b0, 1'b1, 2'd2);
    cyc(1'b0, 1'b1, 2'd2);
    check("t6_k3", o_pix, 12'h300);
    cyc(1'b1, 1'b1, 2'd2);
    check("t6_done_act", active_sel, 1);
    check("t6_done_busy", busy, 0);
    cyc(1'b0, 1'b1, 2'd2);
    check("t6_reeval", busy, 1);
    cyc(1'b0, 1'b1, 2'd2);
    check("t6_new", o_pix, 12'h000);
`endif

    // randomized traffic against the model
    rsel = 2'd0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) rsel = SEL_W'($urandom_range(0, 3));
      src_pix = SRC_W'({$urandom(), $urandom()});
      if ($urandom_range(0, 399) == 0) do_reset();
      cyc(bit'($urandom_range(0, 15) == 0), bit'($urandom_range(0, 9) != 0), rsel);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
